move_sequencer: RTL and testbench
=================================

Name: move_sequencer

Overview:
- Controller that turns one decoded engine move into a serialized stream of single-square writes to the 64-entry board piece register file.
- Handles quiet moves, captures, king/queen-side castling and en passant.
- Sits between the move generator (valid/ready move descriptor) and the board storage (one write port).
- Also records the captured piece for later undo.

Parameters:
- SQ_W, 6, square index width (64 squares; index = 8*rank + file, rank 0 = white back rank, file 0 = a-file).
- PW, 6, piece word width: {color, 5-bit code}; empty square = 6'b000000.

Ports:
- clk  in  1  system clock
- clear_n  in  1  asynchronous active-low reset
- enable  in  1  when low, FSM freezes and wr_en is forced 0
- engineColor  in  1  color of the moving side (0 white, 1 black); sampled on accept
- mv_valid  in  1  move descriptor valid
- mv_ready  out  1  sequencer can accept a move
- initialPosition  in  64  one-hot source square
- movedPosition  in  64  one-hot destination square
- movingPiece  in  6  one-hot: 000001 pawn, 000010 rook, 000100 knight, 001000 bishop, 010000 queen, 100000 king
- capturedPiece  in  6  same coding; 000000 = quiet
- castling  in  3  001 none, 010 queen side, 100 king side
- enpassant  in  5  00001 none, 00010 UL, 00100 UR, 01000 DL, 10000 DR
- wr_en  out  1  board write strobe
- wr_addr  out  6  square index written
- wr_data  out  6  piece word written
- busy  out  1  a move is in progress
- done  out  1  one-cycle pulse when a move completes
- err  out  1  valid with done; move rejected, no writes issued
- last_captured  out  6  piece word removed by the last successful move (0 if quiet)

Behaviour:
- Reset (clear_n low, async): state IDLE; mv_ready=1; wr_en=0; wr_addr=0; wr_data=0; busy=0; done=0; err=0; last_captured=0. Any move in flight is abandoned with no further writes.
- Piece codes: pawn 00010, knight 00001, king 00100, queen 11000, rook 10000, bishop 01000.
- Moving piece word = {engineColor, code}. Captured piece word = {~engineColor, code}.
- Accept: mv_valid && mv_ready && enable at edge T. All inputs are latched and mv_ready drops.
- States: IDLE -> DECODE -> WR_FROM -> WR_TO -> [WR_X1 -> WR_X2] -> DONE -> IDLE.
- DECODE (T+1):
  - Convert the one-hot squares to indices.
  - Validate. Error if any of the following:
    - a square is not exactly one-hot;
    - from == to;
    - movingPiece is not one-hot;
    - capturedPiece is neither zero nor one-hot;
    - castling or enpassant is not one-hot;
    - castling and en passant are both active;
    - castling with a non-king mover;
    - en passant with a non-pawn mover;
    - en passant with capturedPiece != pawn;
    - en passant victim square off the board.
  - On error: go directly to DONE with err=1; last_captured is unchanged.
- Write cycles (one wr_en pulse per state):
  - WR_FROM: addr=from, data=0.
  - WR_TO: addr=to, data=moving word.
- Castling: rook rank = king rank.
  - King side: WR_X1 clears file 7, WR_X2 writes rook word to file 5.
  - Queen side: WR_X1 clears file 0, WR_X2 writes rook word to file 3.
- En passant: WR_X1 clears the victim square. Victim = to-8 for UL/UR, to+8 for DL/DR. WR_X2 is skipped.
- DONE: done=1 for exactly one cycle, busy still 1.
  - On success, last_captured is updated in the same cycle: en passant gives the pawn word, quiet gives 0.
  - Next state IDLE, where mv_ready=1 and busy=0.
- Latency:
  - quiet/capture: writes at T+2 and T+3, done at T+4, ready at T+5;
  - en passant: done at T+5;
  - castling: done at T+6;
  - error: done at T+2.
- busy=1 from T+1 through the DONE cycle.
- enable low: all registers hold, wr_en=0, and no write is lost; the pending write issues on the first enabled cycle.
- mv_valid while busy is ignored; there is no queuing.

Test Plan:
- Quiet knight g1->f3, engineColor=0 -> writes (6,000000) at T+2, (21,000001) at T+3; done at T+4 with err=0; last_captured=0.
- White king-side castle e1->g1, castling=100 -> writes (4,0), (6,000100), (7,0), (5,010000) on consecutive cycles; done at T+6.
- Black en passant e4->d3 DL, captured pawn -> writes (28,0), (19,100010), (27,0); last_captured=000010.
- Error case: from==to, or castling=010 with a pawn mover -> done+err at T+2; no wr_en; last_captured unchanged.
- enable deasserted for 3 cycles at WR_TO -> wr_en stays low, then (to,data) issues once; done is delayed 3 cycles.
- clear_n pulsed during WR_X1 of a castle -> outputs at reset values immediately; no further writes; next move is accepted normally.

Source files
------------

// File: rtl/move_sequencer.sv
// move_sequencer: serializes one decoded engine move into single-square
// writes to the board piece register file, and remembers the captured piece.
module move_sequencer #(
    parameter int unsigned SQ_W = 6,
    parameter int unsigned PW   = 6
) (
    input  logic                 clk,
    input  logic                 clear_n,
    input  logic                 enable,
    input  logic                 engineColor,
    input  logic                 mv_valid,
    output logic                 mv_ready,
    input  logic [2**SQ_W-1:0]   initialPosition,
    input  logic [2**SQ_W-1:0]   movedPosition,
    input  logic [5:0]           movingPiece,
    input  logic [5:0]           capturedPiece,
    input  logic [2:0]           castling,
    input  logic [4:0]           enpassant,
    output logic                 wr_en,
    output logic [SQ_W-1:0]      wr_addr,
    output logic [PW-1:0]        wr_data,
    output logic                 busy,
    output logic                 done,
    output logic                 err,
    output logic [PW-1:0]        last_captured
);

    localparam int unsigned NSQ = 2**SQ_W;
    localparam int unsigned CW  = PW - 1;

    localparam logic [5:0]    PAWN_OH   = 6'b000001;
    localparam logic [5:0]    KING_OH   = 6'b100000;
    localparam logic [CW-1:0] ROOK_CODE = CW'(5'b10000);

    typedef enum logic [2:0] {
        IDLE, DECODE, WR_FROM, WR_TO, WR_X1, WR_X2, DONE
    } state_t;

    state_t            state;
    logic [NSQ-1:0]    fromR;
    logic [NSQ-1:0]    toR;
    logic [5:0]        moverR;
    logic [5:0]        captR;
    logic [2:0]        castR;
    logic [4:0]        epR;
    logic              colorR;
    logic [SQ_W-1:0]   toIdxR;
    logic              wrPend;

    logic [SQ_W-1:0]   fromIdx;
    logic [SQ_W-1:0]   toIdx;
    logic [SQ_W-1:0]   victimIdx;
    logic [SQ_W-4:0]   rank;
    logic              castKs;
    logic              castAct;
    logic              epUp;
    logic              epDown;
    logic              epAct;
    logic              decodeErr;
    logic [PW-1:0]     moveWord;
    logic [PW-1:0]     rookWord;
    logic [PW-1:0]     capWord;

    function automatic logic isOneHot(input logic [NSQ-1:0] v);
        return (v != '0) && ((v & (v - NSQ'(1))) == '0);
    endfunction

    // Lowest set bit; only meaningful once the vector is known one-hot.
    function automatic logic [SQ_W-1:0] sqIndex(input logic [NSQ-1:0] v);
        logic [SQ_W-1:0] idx;
        idx = '0;
        for (int i = NSQ - 1; i >= 0; i--) begin
            if (v[i]) idx = SQ_W'(i);
        end
        return idx;
    endfunction

    function automatic logic [CW-1:0] pieceCode(input logic [5:0] oh);
        logic [CW-1:0] code;
        case (oh)
            6'b000001: code = CW'(5'b00010);
            6'b000010: code = CW'(5'b10000);
            6'b000100: code = CW'(5'b00001);
            6'b001000: code = CW'(5'b01000);
            6'b010000: code = CW'(5'b11000);
            6'b100000: code = CW'(5'b00100);
            default:   code = '0;
        endcase
        return code;
    endfunction

    assign castKs    = castR[2];
    assign castAct   = castR[2] | castR[1];
    assign epUp      = epR[1] | epR[2];
    assign epDown    = epR[3] | epR[4];
    assign epAct     = epUp | epDown;
    assign rank      = toIdxR[SQ_W-1:3];
    assign victimIdx = epUp ? (toIdxR - SQ_W'(8)) : (toIdxR + SQ_W'(8));
    assign moveWord  = {colorR, pieceCode(moverR)};
    assign rookWord  = {colorR, ROOK_CODE};
    assign capWord   = (captR == '0) ? '0 : {~colorR, pieceCode(captR)};
    assign wr_en     = wrPend & enable;

    // Square decode and move legality screen on the latched descriptor.
    always_comb begin
        fromIdx   = sqIndex(fromR);
        toIdx     = sqIndex(toR);
        decodeErr = 1'b0;
        if (!isOneHot(fromR) || !isOneHot(toR) || (fromIdx == toIdx)) decodeErr = 1'b1;
        if (!isOneHot(NSQ'(moverR)))                                  decodeErr = 1'b1;
        if ((captR != '0) && !isOneHot(NSQ'(captR)))                  decodeErr = 1'b1;
        if (!isOneHot(NSQ'(castR)) || !isOneHot(NSQ'(epR)))           decodeErr = 1'b1;
        if (castAct && epAct)                                         decodeErr = 1'b1;
        if (castAct && (moverR != KING_OH))                           decodeErr = 1'b1;
        if (epAct && ((moverR != PAWN_OH) || (captR != PAWN_OH)))     decodeErr = 1'b1;
        if (epUp && (toIdx < SQ_W'(8)))                               decodeErr = 1'b1;
        if (epDown && (toIdx >= SQ_W'(NSQ - 8)))                      decodeErr = 1'b1;
    end

    // Sequencer FSM; every register freezes while enable is low.
    always_ff @(posedge clk or negedge clear_n) begin
        if (!clear_n) begin
            state         <= IDLE;
            mv_ready      <= 1'b1;
            wrPend        <= 1'b0;
            wr_addr       <= '0;
            wr_data       <= '0;
            busy          <= 1'b0;
            done          <= 1'b0;
            err           <= 1'b0;
            last_captured <= '0;
            fromR         <= '0;
            toR           <= '0;
            moverR        <= '0;
            captR         <= '0;
            castR         <= '0;
            epR           <= '0;
            colorR        <= 1'b0;
            toIdxR        <= '0;
        end else if (enable) begin
            wrPend <= 1'b0;
            done   <= 1'b0;
            err    <= 1'b0;
            case (state)
                IDLE: begin
                    if (mv_valid) begin
                        fromR    <= initialPosition;
                        toR      <= movedPosition;
                        moverR   <= movingPiece;
                        captR    <= capturedPiece;
                        castR    <= castling;
                        epR      <= enpassant;
                        colorR   <= engineColor;
                        mv_ready <= 1'b0;
                        busy     <= 1'b1;
                        state    <= DECODE;
                    end
                end
                DECODE: begin
                    toIdxR <= toIdx;
                    if (decodeErr) begin
                        done  <= 1'b1;
                        err   <= 1'b1;
                        state <= DONE;
                    end else begin
                        wrPend  <= 1'b1;
                        wr_addr <= fromIdx;
                        wr_data <= '0;
                        state   <= WR_FROM;
                    end
                end
                WR_FROM: begin
                    wrPend  <= 1'b1;
                    wr_addr <= toIdxR;
                    wr_data <= moveWord;
                    state   <= WR_TO;
                end
                WR_TO: begin
                    if (castAct) begin
                        wrPend  <= 1'b1;
                        wr_addr <= {rank, castKs ? 3'd7 : 3'd0};
                        wr_data <= '0;
                        state   <= WR_X1;
                    end else if (epAct) begin
                        wrPend  <= 1'b1;
                        wr_addr <= victimIdx;
                        wr_data <= '0;
                        state   <= WR_X1;
                    end else begin
                        done          <= 1'b1;
                        last_captured <= capWord;
                        state         <= DONE;
                    end
                end
                WR_X1: begin
                    if (castAct) begin
                        wrPend  <= 1'b1;
                        wr_addr <= {rank, castKs ? 3'd5 : 3'd3};
                        wr_data <= rookWord;
                        state   <= WR_X2;
                    end else begin
                        done          <= 1'b1;
                        last_captured <= capWord;
                        state         <= DONE;
                    end
                end
                WR_X2: begin
                    done          <= 1'b1;
                    last_captured <= capWord;
                    state         <= DONE;
                end
                DONE: begin
                    mv_ready <= 1'b1;
                    busy     <= 1'b0;
                    state    <= IDLE;
                end
                default: state <= IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_move_sequencer.sv
// Bench for move_sequencer: directed moves plus randomized moves scored
// against a move-level reference model (write list, latency, captured piece).
module tb_move_sequencer;

    logic        clk = 1'b0;
    logic        clear_n = 1'b1;
    logic        enable = 1'b0;
    logic        engineColor = 1'b0;
    logic        mv_valid = 1'b0;
    logic        mv_ready;
    logic [63:0] initialPosition = '0;
    logic [63:0] movedPosition = '0;
    logic [5:0]  movingPiece = '0;
    logic [5:0]  capturedPiece = '0;
    logic [2:0]  castling = 3'b001;
    logic [4:0]  enpassant = 5'b00001;
    logic        wr_en;
    logic [5:0]  wr_addr;
    logic [5:0]  wr_data;
    logic        busy;
    logic        done;
    logic        err;
    logic [5:0]  last_captured;

    int total = 0;
    int bad = 0;

    int          expQ[$];
    logic        expErr;
    int          expDone;
    logic [5:0]  expLast = '0;
    logic [4:0]  codeTbl [6] = '{5'b00010, 5'b10000, 5'b00001, 5'b01000, 5'b11000, 5'b00100};

    always #5 clk = ~clk;

    move_sequencer dut (
        .clk             (clk),
        .clear_n         (clear_n),
        .enable          (enable),
        .engineColor     (engineColor),
        .mv_valid        (mv_valid),
        .mv_ready        (mv_ready),
        .initialPosition (initialPosition),
        .movedPosition   (movedPosition),
        .movingPiece     (movingPiece),
        .capturedPiece   (capturedPiece),
        .castling        (castling),
        .enpassant       (enpassant),
        .wr_en           (wr_en),
        .wr_addr         (wr_addr),
        .wr_data         (wr_data),
        .busy            (busy),
        .done            (done),
        .err             (err),
        .last_captured   (last_captured)
    );

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        total++;
        assert (obs === exp) else begin
            bad++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    function automatic logic [63:0] sq(input int i);
        return 64'(1) << i;
    endfunction

    function automatic int firstBit(input logic [63:0] v);
        for (int i = 0; i < 64; i++) if (v[i]) return i;
        return 0;
    endfunction

    // Reference: expected board writes (addr*256+data), error, done cycle, captured word.
    task automatic predict(input logic [63:0] f, input logic [63:0] t, input logic [5:0] mp,
                           input logic [5:0] cp, input logic [2:0] ca, input logic [4:0] ep,
                           input logic col);
        bit ok, isCastle, isEp, epUpward;
        int fi, ti, vic, row;
        logic [5:0] moveWord, rookWord;
        ok = ($countones(f) == 1) && ($countones(t) == 1) && (f != t) &&
             ($countones(mp) == 1) && ($countones(cp) <= 1) &&
             ($countones(ca) == 1) && ($countones(ep) == 1);
        isCastle = (ca == 3'b010) || (ca == 3'b100);
        isEp     = (ep != 5'b00001) && ($countones(ep) == 1);
        epUpward = (ep == 5'b00010) || (ep == 5'b00100);
        fi = firstBit(f);
        ti = firstBit(t);
        vic = epUpward ? ti - 8 : ti + 8;
        if (isCastle && isEp) ok = 0;
        if (isCastle && mp != 6'b100000) ok = 0;
        if (isEp && (mp != 6'b000001 || cp != 6'b000001)) ok = 0;
        if (isEp && (vic < 0 || vic > 63)) ok = 0;
        expQ.delete();
        if (!ok) begin
            expErr  = 1'b1;
            expDone = 2;
            return;
        end
        expErr   = 1'b0;
        moveWord = {col, codeTbl[firstBit(64'(mp))]};
        rookWord = {col, 5'b10000};
        row      = ti / 8;
        expQ.push_back(fi * 256);
        expQ.push_back(ti * 256 + int'(moveWord));
        if (ca == 3'b100) begin
            expQ.push_back((row * 8 + 7) * 256);
            expQ.push_back((row * 8 + 5) * 256 + int'(rookWord));
        end else if (ca == 3'b010) begin
            expQ.push_back((row * 8 + 0) * 256);
            expQ.push_back((row * 8 + 3) * 256 + int'(rookWord));
        end else if (isEp) begin
            expQ.push_back(vic * 256);
        end
        expDone = 2 + expQ.size();
        expLast = (cp == 6'b0) ? 6'b0 : {~col, codeTbl[firstBit(64'(cp))]};
    endtask

    // Offer one move, optionally drop enable for stallLen cycles from cycle stallAt0.
    task automatic runMove(input logic [63:0] f, input logic [63:0] t, input logic [5:0] mp,
                           input logic [5:0] cp, input logic [2:0] ca, input logic [4:0] ep,
                           input logic col, input int stallAt0, input int stallLen);
        int k, nW, c, stallAt, doneAt;
        bit gotDone;
        predict(f, t, mp, cp, ca, ep, col);
        stallAt = stallAt0;
        if (stallLen > 0 && stallAt >= expDone) stallAt = expDone - 1;
        doneAt = expDone + ((stallLen > 0 && stallAt < expDone) ? stallLen : 0);
        @(negedge clk);
        enable = 1'b1;
        initialPosition = f;
        movedPosition = t;
        movingPiece = mp;
        capturedPiece = cp;
        castling = ca;
        enpassant = ep;
        engineColor = col;
        mv_valid = 1'b1;
        check("ready_idle", 32'(mv_ready), 32'd1);
        @(posedge clk);
        #1;
        mv_valid = 1'b0;
        k = 0;
        nW = 0;
        gotDone = 0;
        while (!gotDone && k < 40) begin
            k++;
            @(negedge clk);
            enable = !(stallLen > 0 && k >= stallAt && k < stallAt + stallLen);
            #1;
            if (wr_en) begin
                c = 2 + nW;
                if (stallLen > 0 && stallAt <= c) c += stallLen;
                if (nW < expQ.size()) begin
                    check("wr_word", 32'(int'(wr_addr) * 256 + int'(wr_data)), 32'(expQ[nW]));
                    check("wr_cycle", 32'(k), 32'(c));
                end else begin
                    check("wr_extra", 32'(nW + 1), 32'(expQ.size()));
                end
                nW++;
            end
            if (done) gotDone = 1;
        end
        check("done_seen", 32'(gotDone), 32'd1);
        check("done_cycle", 32'(k), 32'(doneAt));
        check("err", 32'(err), 32'(expErr));
        check("busy_at_done", 32'(busy), 32'd1);
        check("write_count", 32'(nW), 32'(expQ.size()));
        check("last_captured", 32'(last_captured), 32'(expLast));
        @(negedge clk);
        enable = 1'b1;
        #1;
        check("done_pulse", 32'(done), 32'd0);
        check("ready_after", 32'(mv_ready), 32'd1);
        check("busy_after", 32'(busy), 32'd0);
    endtask

    initial begin
        logic [63:0] f, t;
        logic [5:0]  mp, cp;
        logic [2:0]  ca;
        logic [4:0]  ep;
        logic        col;
        int          fi, ti, r, kind, sAt, sLen;
        bit          ks;

        // Reset values
        #2 clear_n = 1'b0;
        #3;
        check("rst_ready", 32'(mv_ready), 32'd1);
        check("rst_wr_en", 32'(wr_en), 32'd0);
        check("rst_wr_addr", 32'(wr_addr), 32'd0);
        check("rst_wr_data", 32'(wr_data), 32'd0);
        check("rst_busy", 32'(busy), 32'd0);
        check("rst_done", 32'(done), 32'd0);
        check("rst_err", 32'(err), 32'd0);
        check("rst_last", 32'(last_captured), 32'd0);
        @(negedge clk);
        clear_n = 1'b1;
        enable = 1'b1;

        // Quiet knight g1->f3
        runMove(sq(6), sq(21), 6'b000100, 6'b0, 3'b001, 5'b00001, 1'b0, 0, 0);
        // White king-side castle e1->g1
        runMove(sq(4), sq(6), 6'b100000, 6'b0, 3'b100, 5'b00001, 1'b0, 0, 0);
        // Black queen-side castle e8->c8
        runMove(sq(60), sq(58), 6'b100000, 6'b0, 3'b010, 5'b00001, 1'b1, 0, 0);
        // Black en passant e4->d3 (DL)
        runMove(sq(28), sq(19), 6'b000001, 6'b000001, 3'b001, 5'b01000, 1'b1, 0, 0);
        // White queen d1 takes rook d8
        runMove(sq(3), sq(59), 6'b010000, 6'b000010, 3'b001, 5'b00001, 1'b0, 0, 0);
        // Errors: from==to, pawn castling, en passant victim off board
        runMove(sq(12), sq(12), 6'b000001, 6'b0, 3'b001, 5'b00001, 1'b0, 0, 0);
        runMove(sq(12), sq(20), 6'b000001, 6'b0, 3'b010, 5'b00001, 1'b0, 0, 0);
        runMove(sq(9), sq(2), 6'b000001, 6'b000001, 3'b001, 5'b00010, 1'b0, 0, 0);
        // Enable dropped for 3 cycles during WR_TO
        runMove(sq(1), sq(18), 6'b000100, 6'b0, 3'b001, 5'b00001, 1'b0, 3, 3);

        // Reset in the middle of a castle (WR_X1 cycle)
        @(negedge clk);
        initialPosition = sq(4);
        movedPosition = sq(6);
        movingPiece = 6'b100000;
        capturedPiece = 6'b0;
        castling = 3'b100;
        enpassant = 5'b00001;
        engineColor = 1'b0;
        mv_valid = 1'b1;
        @(posedge clk);
        #1;
        mv_valid = 1'b0;
        repeat (4) @(negedge clk);
        #1;
        check("x1_wr_en", 32'(wr_en), 32'd1);
        check("x1_wr_addr", 32'(wr_addr), 32'd7);
        clear_n = 1'b0;
        #1;
        check("clr_wr_en", 32'(wr_en), 32'd0);
        check("clr_wr_addr", 32'(wr_addr), 32'd0);
        check("clr_busy", 32'(busy), 32'd0);
        check("clr_ready", 32'(mv_ready), 32'd1);
        check("clr_last", 32'(last_captured), 32'd0);
        expLast = '0;
        @(negedge clk);
        clear_n = 1'b1;
        for (int i = 0; i < 5; i++) begin
            @(negedge clk);
            #1;
            check("clr_no_write", 32'(wr_en), 32'd0);
            check("clr_no_done", 32'(done), 32'd0);
        end
        runMove(sq(52), sq(36), 6'b000001, 6'b0, 3'b001, 5'b00001, 1'b1, 0, 0);

        // Randomized moves
        for (int n = 0; n < 40; n++) begin
            kind = int'($urandom_range(0, 3));
            col  = 1'($urandom_range(0, 1));
            fi   = int'($urandom_range(0, 63));
            ti   = int'($urandom_range(0, 63));
            mp   = 6'(1) << $urandom_range(0, 5);
            cp   = ($urandom_range(0, 2) == 0) ? 6'b0 : 6'(6'(1) << $urandom_range(0, 5));
            ca   = 3'b001;
            ep   = 5'b00001;
            f    = sq(fi);
            t    = sq(ti);
            case (kind)
                1: begin
                    r  = col ? 7 : 0;
                    ks = 1'($urandom_range(0, 1));
                    mp = 6'b100000;
                    cp = 6'b0;
                    f  = sq(r * 8 + 4);
                    t  = sq(r * 8 + (ks ? 6 : 2));
                    ca = ks ? 3'b100 : 3'b010;
                end
                2: begin
                    mp = 6'b000001;
                    cp = 6'b000001;
                    ep = 5'(5'(1) << $urandom_range(1, 4));
                end
                3: begin
                    f  = {$urandom, $urandom};
                    mp = 6'($urandom);
                    cp = 6'($urandom);
                    ca = 3'($urandom);
                    ep = 5'($urandom);
                end
                default: ;
            endcase
            sLen = ($urandom_range(0, 3) == 0) ? int'($urandom_range(1, 3)) : 0;
            sAt  = int'($urandom_range(1, 6));
            runMove(f, t, mp, cp, ca, ep, col, sAt, sLen);
        end

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
